// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store memory access controller:
// data width, RV32I load/store funct3 codes, FSM state encoding and
// request classification helpers.
package mem_access_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Legal RV32I funct3 encodings for loads and stores.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else    ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                     (f3 == F3_LBU) || (f3 == F3_LHU);
        return ok;
    endfunction

    // An access is misaligned when it crosses a word boundary:
    // halfwords at offset 3, words at any non-zero offset.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'd1:    mis = (off == 2'd3);
            2'd2:    mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mod_mem_store_data_aligner.sv
// Lane placement for memory accesses: produces the byte enables and the
// shifted store data over a two-word window. Lanes [3:0] / [31:0] belong to
// the first beat, lanes [7:4] / [63:32] to the second beat of a split access.
module mod_mem_store_data_aligner
    import mem_access_pkg::*;
(
    input  logic [1:0]        size_i,   // funct3[1:0]: 0 byte, 1 half, 2 word
    input  logic [1:0]        off_i,    // byte offset within the first word
    input  logic [XLEN-1:0]   wdata_i,
    output logic [7:0]        be_o,
    output logic [2*XLEN-1:0] wdata_o
);

    logic [7:0]      mask;
    logic [XLEN-1:0] sized;

    // Size mask and zero-extended store data, then shift both into place.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mask  = 8'h00;
        sized = '0;
        case (size_i)
            2'd0: begin
                mask  = 8'h01;
                sized = {{(XLEN-8){1'b0}}, wdata_i[7:0]};
            end
            2'd1: begin
                mask  = 8'h03;
                sized = {{(XLEN-16){1'b0}}, wdata_i[15:0]};
            end
            2'd2: begin
                mask  = 8'h0F;
                sized = wdata_i;
            end
            default: ;
        endcase
        be_o    = mask << off_i;
        wdata_o = {{XLEN{1'b0}}, sized} << {off_i, 3'b000};
    end

endmodule

// File: rtl/mod_mem_access_ctrl.sv
// RV32I load/store access controller: one outstanding request, word-wide
// memory bus with grant and read-valid, byte-lane alignment and load extension.
// Optional feature: define MEM_MISALIGNED_SPLIT_EN to execute word-crossing
// accesses as two beats; otherwise they are rejected with rsp_err_o.
module mod_mem_access_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);
    import mem_access_pkg::*;

`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] beat0_q, beat0_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [1:0]        off;
    logic              split;
    logic [XLEN-1:0]   word_addr;
    logic [XLEN-1:0]   next_addr;
    logic [7:0]        be8;
    logic [2*XLEN-1:0] wdata64;

    assign off       = addr_q[1:0];
    assign split     = SPLIT_EN && is_misaligned(funct3_q, off);
    assign word_addr = {addr_q[XLEN-1:2], 2'b00};
    assign next_addr = word_addr + XLEN'(4);  // wraps modulo 2^32

    // Select the addressed bytes from {beat1, beat0} and extend to XLEN.
    function automatic logic [XLEN-1:0] extract_load(input logic [2:0] f3,
                                                     input logic [1:0] o,
                                                     input logic [2*XLEN-1:0] beats);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = XLEN'(beats >> {o, 3'b000});
        case (f3)
            F3_LB:   res = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_LH:   res = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_LBU:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_LHU:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
            F3_LW:   res = sh;
            default: res = '0;
        endcase
        return res;
    endfunction

    mod_mem_store_data_aligner u_aligner (
        .size_i  (funct3_q[1:0]),
        .off_i   (off),
        .wdata_i (wdata_q),
        .be_o    (be8),
        .wdata_o (wdata64)
    );

    // Next-state and datapath-register logic of the access FSM.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        beat0_d  = beat0_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = '0;
                    if (!is_legal(req_we_i, req_funct3_i) ||
                        (!SPLIT_EN && is_misaligned(req_funct3_i, req_addr_i[1:0]))) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ0;
                    end
                end
            end
            ST_REQ0:  if (mem_gnt_i) state_d = ST_WAIT0;
            ST_REQ1:  if (mem_gnt_i) state_d = ST_WAIT1;
            ST_WAIT0: begin
                if (mem_rvalid_i) begin
                    if (mem_err_i) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (split) begin
                        beat0_d = mem_rdata_i;
                        state_d = ST_REQ1;
                    end else begin
                        rdata_d = we_q ? '0 : extract_load(funct3_q, off, {{XLEN{1'b0}}, mem_rdata_i});
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT1: begin
                if (mem_rvalid_i) begin
                    err_d   = mem_err_i;
                    rdata_d = (we_q || mem_err_i) ? '0 : extract_load(funct3_q, off, {mem_rdata_i, beat0_q});
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            beat0_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            beat0_q  <= beat0_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bus request outputs: driven only in REQ0/REQ1, zero otherwise.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        if (state_q == ST_REQ0) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = word_addr;
            mem_be_o    = be8[3:0];
            mem_wdata_o = we_q ? wdata64[XLEN-1:0] : '0;
        end else if (state_q == ST_REQ1) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = next_addr;
            mem_be_o    = be8[7:4];
            mem_wdata_o = we_q ? wdata64[2*XLEN-1:XLEN] : '0;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o & err_q;

endmodule

// File: tb/tb_mod_mem_access_ctrl.sv
// Scoreboard bench for mod_mem_access_ctrl: a byte-level reference model
// pushes expected bus beats and responses; a memory responder and a
// response monitor pop and compare independently of the stimulus.
`timescale 1ns/1ps
module tb_mod_mem_access_ctrl;

`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    mod_mem_access_ctrl #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        int          gnt_wait;
        int          rv_delay;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    beat_t     beat_q[$];
    beat_t     seen_q[$];
    rsp_t      rsp_q[$];
    bit [31:0] ref_mem [bit [31:0]];
    bit [31:0] slv_mem [bit [31:0]];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          last_rsp_cyc = 0;
    int          rsp_cnt = 0;
    int          last_req_cycles = 0;
    logic [31:0] last_rsp_rdata = '0;
    logic        last_rsp_err = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    function automatic bit [31:0] rd_ref(input bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic bit [31:0] rd_slv(input bit [31:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return init_word(a);
    endfunction

    task automatic set_word(input bit [31:0] a, input bit [31:0] v);
        ref_mem[a] = v;
        slv_mem[a] = v;
    endtask

    // Reference model: works byte by byte over the addressed bytes.
    task automatic model_issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int gw, input int rvd, input int eb);
        bit        legal;
        int        size, off, nbeats;
        bit [31:0] base, val, w;
        bit [31:0] words[2];
        bit [3:0]  be[2];
        bit [31:0] wd[2];
        rsp_t      r;
        beat_t     b;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        off   = int'(addr % 4);
        base  = addr - 32'(off);
        r.rdata = '0;
        r.err   = 1'b0;
        if (!legal || (off + size > 4 && !SPLIT)) begin
            r.err = 1'b1;
            rsp_q.push_back(r);
            return;
        end
        nbeats = (off + size > 4) ? 2 : 1;
        for (int k = 0; k < 2; k++) begin
            words[k] = rd_ref(base + 32'(4 * k));
            be[k] = '0;
            wd[k] = '0;
        end
        val = '0;
        for (int i = 0; i < size; i++) begin
            int p;
            p = off + i;
            be[p / 4][p % 4] = 1'b1;
            if (we) wd[p / 4][(p % 4) * 8 +: 8] = wdata[i * 8 +: 8];
            val[i * 8 +: 8] = words[p / 4][(p % 4) * 8 +: 8];
        end
        for (int k = 0; k < nbeats; k++) begin
            b.addr = base + 32'(4 * k);
            b.we = we; b.be = be[k]; b.wdata = wd[k];
            b.err = (k == eb); b.gnt_wait = gw; b.rv_delay = rvd;
            beat_q.push_back(b);
            if (b.err) begin
                r.err = 1'b1;
                break;
            end
            if (we) begin
                w = rd_ref(b.addr);
                for (int l = 0; l < 4; l++)
                    if (be[k][l]) w[l * 8 +: 8] = wd[k][l * 8 +: 8];
                ref_mem[b.addr] = w;
            end
        end
        if (!r.err && !we) begin
            if (f3 == 3'd0) val = {{24{val[7]}}, val[7:0]};
            if (f3 == 3'd1) val = {{16{val[15]}}, val[15:0]};
            r.rdata = val;
        end
        rsp_q.push_back(r);
    endtask

    // Driver: wait for ready, present one request for one cycle.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gw, input int rvd, input int eb);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("req_ready_before_issue", {31'b0, req_ready_o}, 32'd1);
        if (!req_ready_o) return;
        model_issue(we, f3, addr, wdata, gw, rvd, eb);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        accept_cyc   = cyc;
        @(posedge clk_i);
        #1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'($urandom);
        req_funct3_i = 3'($urandom);
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || beat_q.size() != 0) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_in_time", {31'b0, (n < 300)}, 32'd1);
        repeat (2) @(negedge clk_i);
    endtask

    // Response monitor: compares each presented response with the scoreboard.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                last_rsp_cyc   = cyc;
                last_rsp_rdata = rsp_rdata_o;
                last_rsp_err   = rsp_err_o;
                rsp_cnt++;
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", {31'b0, rsp_valid_o}, 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                    check("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
                end
            end else begin
                check("idle_rsp_rdata_zero", rsp_rdata_o, 32'd0);
                check("idle_rsp_err_zero", {31'b0, rsp_err_o}, 32'd0);
            end
        end
    end

    // Memory responder: checks every request cycle against the expected beat,
    // grants after the beat's wait, returns read data after its delay.
    initial begin : responder
        beat_t       cur, act;
        bit          have_cur, rv_pending;
        int          wait_cnt, req_cycles, rv_cnt;
        logic [31:0] rv_data;
        logic        rv_err;
        bit [31:0]   w;
        have_cur = 1'b0; rv_pending = 1'b0;
        wait_cnt = 0; req_cycles = 0; rv_cnt = 0;
        rv_data = '0; rv_err = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
            mem_rdata_i = $urandom;
            if (rv_pending) begin
                if (rv_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rv_data;
                    mem_err_i    = rv_err;
                    rv_pending   = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (mem_req_o && rst_ni) begin
                if (!have_cur) begin
                    if (beat_q.size() == 0) begin
                        check("mem_req_unexpected", {31'b0, mem_req_o}, 32'd0);
                        cur = '{addr: mem_addr_o, we: mem_we_o, be: mem_be_o, wdata: mem_wdata_o,
                                err: 1'b1, gnt_wait: 0, rv_delay: 0};
                    end else begin
                        cur = beat_q.pop_front();
                    end
                    have_cur = 1'b1;
                    wait_cnt = cur.gnt_wait;
                    req_cycles = 0;
                end
                req_cycles++;
                check("mem_addr", mem_addr_o, cur.addr);
                check("mem_we", {31'b0, mem_we_o}, {31'b0, cur.we});
                check("mem_be", {28'b0, mem_be_o}, {28'b0, cur.be});
                check("mem_wdata", mem_wdata_o, cur.wdata);
                if (wait_cnt == 0) begin
                    mem_gnt_i = 1'b1;
                    act = '{addr: mem_addr_o, we: mem_we_o, be: mem_be_o, wdata: mem_wdata_o,
                            err: cur.err, gnt_wait: 0, rv_delay: 0};
                    seen_q.push_back(act);
                    last_req_cycles = req_cycles;
                    w = rd_slv(mem_addr_o);
                    if (mem_we_o && !cur.err) begin
                        for (int l = 0; l < 4; l++)
                            if (mem_be_o[l]) w[l * 8 +: 8] = mem_wdata_o[l * 8 +: 8];
                        slv_mem[mem_addr_o] = w;
                    end
                    rv_data    = w;
                    rv_err     = cur.err;
                    rv_pending = 1'b1;
                    rv_cnt     = cur.rv_delay;
                    have_cur   = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, cnt_before;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
        req_addr_i = '0; req_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        rst_ni = 1'b1;

        // LB from byte 3 of a negative-top-byte word, immediate grant.
        set_word(32'h100, 32'h80AABBCC);
        issue(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, -1);
        wait_idle();
        check("lb_rdata", last_rsp_rdata, 32'hFFFFFF80);
        check("lb_err", {31'b0, last_rsp_err}, 32'd0);
        check("lb_latency", 32'(last_rsp_cyc - accept_cyc), 32'd3);

        // SH to offset 2.
        seen_q.delete();
        issue(1'b1, 3'd1, 32'h202, 32'h00001234, 0, 0, -1);
        wait_idle();
        check("sh_beats", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) begin
            check("sh_addr", seen_q[0].addr, 32'h200);
            check("sh_be", {28'b0, seen_q[0].be}, 32'hC);
            check("sh_wdata", seen_q[0].wdata, 32'h12340000);
        end
        check("sh_rdata", last_rsp_rdata, 32'd0);

        // LW crossing a word boundary.
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        seen_q.delete();
        issue(1'b0, 3'd2, 32'h101, 32'h0, 0, 0, -1);
        wait_idle();
`ifdef MEM_MISALIGNED_SPLIT_EN
        check("lw_split_beats", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("lw_split_addr0", seen_q[0].addr, 32'h100);
            check("lw_split_addr1", seen_q[1].addr, 32'h104);
        end
        check("lw_split_rdata", last_rsp_rdata, 32'h55443322);
        check("lw_split_err", {31'b0, last_rsp_err}, 32'd0);
`else
        check("lw_mis_no_bus", 32'(seen_q.size()), 32'd0);
        check("lw_mis_err", {31'b0, last_rsp_err}, 32'd1);
        check("lw_mis_rdata", last_rsp_rdata, 32'd0);
`endif

        // Grant withheld for 5 cycles: request held stable until granted.
        issue(1'b0, 3'd2, 32'h400, 32'h0, 5, 1, -1);
        wait_idle();
        check("gnt_wait_req_cycles", 32'(last_req_cycles), 32'd6);

        // Bus error on an aligned load.
        issue(1'b0, 3'd2, 32'h404, 32'h0, 0, 0, 0);
        wait_idle();
        check("bus_err_err", {31'b0, last_rsp_err}, 32'd1);
        check("bus_err_rdata", last_rsp_rdata, 32'd0);

`ifdef MEM_MISALIGNED_SPLIT_EN
        // Bus error on the first beat of a split access: no second beat.
        seen_q.delete();
        issue(1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 0);
        wait_idle();
        check("split_err_beats", 32'(seen_q.size()), 32'd1);
        check("split_err_err", {31'b0, last_rsp_err}, 32'd1);
        check("split_err_rdata", last_rsp_rdata, 32'd0);
`endif

        // Word access at the top of the address space.
        seen_q.delete();
        issue(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 0, 0, -1);
        wait_idle();
`ifdef MEM_MISALIGNED_SPLIT_EN
        check("wrap_beats", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("wrap_addr0", seen_q[0].addr, 32'hFFFFFFFC);
            check("wrap_addr1", seen_q[1].addr, 32'h00000000);
        end
`else
        check("wrap_no_bus", 32'(seen_q.size()), 32'd0);
        check("wrap_err", {31'b0, last_rsp_err}, 32'd1);
`endif

        // Reset pulsed while waiting for read data of a granted beat.
        seen_q.delete();
        cnt_before = rsp_cnt;
        issue(1'b0, 3'd2, 32'h300, 32'h0, 0, 6, -1);
        n = 0;
        while (seen_q.size() == 0 && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("reset_test_granted", 32'(seen_q.size()), 32'd1);
        rst_ni = 1'b0;
        rsp_q.delete();
        #1;
        check("inflight_rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("inflight_rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("inflight_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (12) @(negedge clk_i);
        check("after_rst_no_rsp", 32'(rsp_cnt), 32'(cnt_before));
        check("after_rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("after_rst_mem_req", {31'b0, mem_req_o}, 32'd0);

        // Randomized traffic over a small overlapping region and the wrap point.
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          eb;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) f3 = we ? 3'($urandom_range(0, 2))
                                                  : 3'($urandom_range(0, 4));
            else                          f3 = 3'($urandom_range(0, 7));
            if (!we && f3 == 3'd3 && $urandom_range(0, 1) == 1) f3 = 3'd5;
            if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else                           addr = 32'h1000 + 32'($urandom_range(0, 63));
            eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
            issue(we, f3, addr, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), eb);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_mem_access_ctrl.md
MOD_MEM_ACCESS_CTRL -- requirements
Module: mod_mem_access_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have clk_i  in  1  single clock; all state on rising edge.
REQ-003 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  in  1 / req_ready_o  out  1  pipeline request handshake.
REQ-005 SHALL have req_we_i  in  1 (store=1); req_funct3_i  in  3  RV32I load/store funct3; req_addr_i  in  32  byte address; req_wdata_i  in  32  store data in bits [size-1:0].
REQ-006 SHALL have rsp_valid_o  out  1; rsp_rdata_o  out  32  aligned, extended load data; rsp_err_o  out  1  access fault or misalignment.
REQ-007 SHALL have mem_req_o  out  1; mem_gnt_i  in  1; mem_we_o  out  1; mem_addr_o  out  32  word address, bits[1:0]=0; mem_be_o  out  4; mem_wdata_o  out  32.
REQ-008 SHALL have mem_rvalid_i  in  1; mem_rdata_i  in  32; mem_err_i  in  1  (valid with mem_rvalid_i).

Function
REQ-009 SHALL use FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; req_ready_o = (state==IDLE).
REQ-010 SHALL accept a request when req_valid_i && req_ready_o, registering we, funct3, addr, wdata; one transaction outstanding.
REQ-011 SHALL go IDLE->REQ0 on a legal accepted request; IDLE->RESP with rsp_err_o=1 and no bus access on illegal funct3 (load 3/6/7, store >2) or unsupported misalignment.
REQ-012 SHALL assert mem_req_o in REQ0/REQ1, holding addr/we/be/wdata stable until mem_gnt_i; REQx->WAITx on grant.
REQ-013 SHALL treat mem_rvalid_i only in WAITx; earliest response is the cycle after grant.
REQ-014 SHALL, on mem_rvalid_i in WAIT0: go REQ1 if split and no error, else RESP; in WAIT1: go RESP.
REQ-015 SHALL assert rsp_valid_o for exactly one cycle in RESP, then return to IDLE; minimum latency accept-to-rsp_valid_o is 3 cycles with same-cycle grant and next-cycle rvalid.
REQ-016 SHALL generate store byte enables: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111, with data shifted left by 8*off; stores give rsp_rdata_o=0.
REQ-017 SHALL form loads from the 64-bit value {beat1, beat0} shifted right by 8*off; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-018 SHALL classify misaligned as LH/LHU/SH with off=3, or LW/SW with off!=0.
REQ-019 SHALL compute second beat address as first+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-020 SHALL, on mem_err_i on any beat, skip remaining beats, set rsp_err_o=1, rsp_rdata_o=0; a store split whose first beat was written is not rolled back.
REQ-021 SHALL hold rsp_rdata_o/rsp_err_o at 0 when rsp_valid_o=0.

Reset
REQ-022 SHALL, while rst_ni=0, force state IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1.
REQ-023 SHALL abandon any in-flight transaction on reset assertion; no response is produced for it and later mem_rvalid_i in IDLE is ignored.

Configuration
REQ-024 SHALL, with MEM_MISALIGNED_SPLIT_EN defined, execute misaligned accesses as two word beats (beat0 lanes off..3, beat1 remaining lanes) per REQ-014..019.
REQ-025 SHALL, without MEM_MISALIGNED_SPLIT_EN, reject misaligned accesses via IDLE->RESP with rsp_err_o=1; REQ1/WAIT1 then unreachable.

Structure
REQ-026 SHALL place funct3 load/store constants, XLEN, and the FSM state enum typedef in shared package mem_access_pkg.
REQ-027 SHALL implement lane placement and byte-enable generation in sub-module mod_mem_store_data_aligner; load extraction stays in the controller.

Verification
REQ-028 SHALL test LB addr 0x103, word 0x80AABBCC, immediate grant -> rsp_rdata_o=0xFFFFFF80, rsp_err_o=0, rsp_valid_o 3 cycles after accept.
REQ-029 SHALL test SH addr 0x202 wdata 0x1234 -> mem_addr_o=0x200, mem_be_o=4'b1100, mem_wdata_o=0x12340000.
REQ-030 SHALL test LW addr 0x101 with split enabled, words 0x44332211 @0x100 and 0x88776655 @0x104 -> two beats, rsp_rdata_o=0x55443322; with macro disabled -> no mem_req_o, rsp_err_o=1.
REQ-031 SHALL test mem_gnt_i held low 5 cycles -> mem_req_o and address stable throughout; mem_err_i on beat0 of split -> no beat1, rsp_err_o=1, rsp_rdata_o=0.
REQ-032 SHALL test LW addr 0xFFFFFFFE (split) -> second mem_addr_o=0x00000000; rst_ni pulsed low in WAIT0 -> IDLE, mem_req_o=0, no rsp_valid_o.
